// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, combinational read, per-word valid bits
// cleared by async reset. Define DATA_MEM_PARITY_EN to add per-word even parity and parity_err.
module data_mem #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
`ifdef DATA_MEM_PARITY_EN
    output logic                  parity_err,
`endif
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_valid;

    logic w_in_range;
    logic w_wr_en;
    logic w_word_valid;

    // The range check only exists when the array is shallower than the address space.
    generate
        if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_range_check
            localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
            assign w_in_range = ({1'b0, addr} < LP_DEPTH);
        end else begin : g_full_range
            assign w_in_range = 1'b1;
        end
    endgenerate

    assign w_wr_en = we & w_in_range;

    // Array contents are never reset; a write landing during reset stays
    // invisible because its valid bit is held clear.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[addr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_wr_en) begin
            r_valid[addr] <= 1'b1;
        end
    end

    assign w_word_valid = w_in_range & r_valid[addr];

    always_comb begin
        read_data = '0;
        if (w_word_valid) begin
            read_data = r_mem[addr];
        end
    end

`ifdef DATA_MEM_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_par[addr] <= ^write_data;
        end
    end

    always_comb begin
        parity_err = 1'b0;
        if (w_word_valid) begin
            parity_err = (r_par[addr] != ^r_mem[addr]);
        end
    end

    // Simulation hook: corrupt one stored data bit without touching its parity.
    task automatic flip_bit(input logic [ADDR_WIDTH-1:0] a, input int unsigned b);
        r_mem[a][b] <= ~r_mem[a][b];
    endtask
`endif

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus randomized traffic
// compared against an associative-array memory model.
module tb_data_mem;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
`ifdef DATA_MEM_PARITY_EN
    logic          parity_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: only addresses written since the last reset exist.
    logic [DW-1:0] model [int];

    data_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .addr       (addr),
        .write_data (write_data),
`ifdef DATA_MEM_PARITY_EN
        .parity_err (parity_err),
`endif
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_read(input int a);
        if (model.exists(a)) return model[a];
        return '0;
    endfunction

    task automatic check_rd(input string name, input logic [DW-1:0] exp);
        n_checks++;
        if (read_data !== exp) begin
            $display("FAIL %s: addr=%h read_data=%h expected=%h", name, addr, read_data, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change 1 time unit after the rising edge, so each edge samples a settled bus.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; addr = a; write_data = d;
        @(posedge clk); #1;
        if (rst_n === 1'b1) model[int'(a)] = d;
        we = 1'b0;
    endtask

    task automatic look(input logic [AW-1:0] a);
        addr = a; #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; we = 1'bx; addr = '0; write_data = '0;
        model.delete();
        repeat (2) @(posedge clk);
        #1; we = 1'b0;
        look(11'h001); check_rd("reset_rd_001", 32'h0);
        look(11'h7FF); check_rd("reset_rd_7ff", 32'h0);
        // write attempted while reset held is ignored
        we = 1'b1; addr = 11'h003; write_data = 32'h12345678;
        @(posedge clk); #1; we = 1'b0;
        look(11'h003); check_rd("reset_write_ignored", 32'h0);
        rst_n = 1'b1;
        #1; check_rd("post_release_still_zero", 32'h0);
    endtask

    task automatic test_write_read;
        do_write(11'h001, 32'hDEADBEEF);
        look(11'h001); check_rd("wr_rd_001", 32'hDEADBEEF);
    endtask

    task automatic test_no_alias;
        do_write(11'h000, 32'h11111111);
        do_write(11'h7FF, 32'h22222222);
        look(11'h000); check_rd("alias_000", 32'h11111111);
        look(11'h7FF); check_rd("alias_7ff", 32'h22222222);
        look(11'h001); check_rd("alias_001", 32'hDEADBEEF);
    endtask

    task automatic test_read_during_write;
        do_write(11'h005, 32'hAAAAAAAA);
        we = 1'b1; addr = 11'h005; write_data = 32'h55555555;
        #1; check_rd("rdw_before_edge", 32'hAAAAAAAA);
        @(posedge clk); #1;
        model[5] = 32'h55555555;
        we = 1'b0;
        check_rd("rdw_after_edge", 32'h55555555);
        // read-during-write on a never-written word shows zero before the edge
        we = 1'b1; addr = 11'h006; write_data = 32'h66666666;
        #1; check_rd("rdw_invalid_before", 32'h0);
        @(posedge clk); #1;
        model[6] = 32'h66666666;
        we = 1'b0;
        check_rd("rdw_invalid_after", 32'h66666666);
    endtask

    task automatic test_back_to_back;
        we = 1'b1; addr = 11'h040; write_data = 32'h00000001;
        @(posedge clk); #1;
        write_data = 32'h00000002;
        @(posedge clk); #1;
        addr = 11'h041; write_data = 32'h00000003;
        @(posedge clk); #1;
        we = 1'b0;
        model[32'h40] = 32'h00000002;
        model[32'h41] = 32'h00000003;
        look(11'h040); check_rd("b2b_last_wins", 32'h00000002);
        look(11'h041); check_rd("b2b_next_addr", 32'h00000003);
    endtask

    task automatic test_reset_recovery;
        do_write(11'h010, 32'hCAFEBABE);
        look(11'h010); check_rd("rec_before_reset", 32'hCAFEBABE);
        #2; rst_n = 1'b0; model.delete();
        #1; check_rd("rec_async_clear", 32'h0);
        look(11'h001); check_rd("rec_other_cleared", 32'h0);
        rst_n = 1'b1;
        do_write(11'h010, 32'h0BADF00D);
        look(11'h010); check_rd("rec_first_write", 32'h0BADF00D);
    endtask

    task automatic test_reset_wins_edge;
        // reset asserted just before the edge that would capture the write
        we = 1'b1; addr = 11'h020; write_data = 32'hFEEDFACE;
        #2; rst_n = 1'b0; model.delete();
        @(posedge clk); #1;
        we = 1'b0;
        rst_n = 1'b1;
        #1; check_rd("reset_wins_edge", 32'h0);
    endtask

    task automatic test_random;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        for (int i = 0; i < 300; i++) begin
            // small window most of the time so reads hit earlier writes
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 2047))
                                            : AW'($urandom_range(0, 15));
            d = $urandom;
            w = ($urandom_range(0, 1) == 1);
            we = w; addr = a; write_data = d;
            #1; check_rd("rand_pre_edge", model_read(int'(a)));
            @(posedge clk); #1;
            if (w) model[int'(a)] = d;
            we = 1'b0;
            check_rd("rand_post_edge", model_read(int'(a)));
        end
    endtask

`ifdef DATA_MEM_PARITY_EN
    task automatic test_parity;
        do_write(11'h020, 32'h00000001);
        addr = 11'h020; #1;
        n_checks++;
        if (parity_err !== 1'b0) $display("FAIL parity_clean: parity_err=%b expected=0", parity_err);
        else n_pass++;
        dut.flip_bit(11'h020, 7);
        #1;
        n_checks++;
        if (parity_err !== 1'b1) $display("FAIL parity_inject: parity_err=%b expected=1", parity_err);
        else n_pass++;
        do_write(11'h020, 32'h00000001);
        addr = 11'h020; #1;
        n_checks++;
        if (parity_err !== 1'b0) $display("FAIL parity_rewrite: parity_err=%b expected=0", parity_err);
        else n_pass++;
    endtask
`endif

    initial begin
        rst_n = 1'b0; we = 1'b0; addr = '0; write_data = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_no_alias();
        test_read_during_write();
        test_back_to_back();
        test_reset_recovery();
        test_reset_wins_edge();
        test_random();
`ifdef DATA_MEM_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
